// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        START,
        WAIT,
        GAP
    } arb_state_t;

    localparam int GAP_MULT [4] = '{0, 1, 2, 4};

    function automatic int gap_cycles(
        input logic [1:0] sel,
        input int         unit
    );
        return GAP_MULT[sel] * unit;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant_id,
    output logic             any_req
);

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_id = '0;
        any_req  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                grant_id = IW'((int'(ptr) + k) % N_REQ);
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between N_REQ packet sources,
// holding a round-robin grant per packet with gap and stall watchdog.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int GAP_UNIT  = 3200,
    parameter int STALL_MAX = 65535
) (
    input  logic                       system_clock,
    input  logic                       cpu_rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*8-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [1:0]                 gap_sel,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       abort,
    output logic [15:0]                byte_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = $clog2(4 * GAP_UNIT + 1);
    localparam int SW = $clog2(STALL_MAX + 1);

    arb_state_t    state;
    arb_state_t    nxt;
    logic [1:0]    gap_r;
    logic          last_r;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_end;
    logic [SW-1:0] stall_cnt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] pick;
    logic          any_req;
    logic          sel_valid;
    logic          stall_hit;
    logic          gap_zero;
    logic          gap_last;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant_id (pick),
        .any_req  (any_req)
    );

    assign sel_valid = req_valid[grant_id];
    assign stall_hit = stall_cnt == SW'(STALL_MAX - 1);
    assign gap_zero  = gap_r == 2'd0;
    assign gap_end   = GW'(gap_cycles(gap_r, GAP_UNIT) - 1);
    assign gap_last  = gap_cnt == gap_end;
    assign nxt_ptr   = (grant_id == IW'(N_REQ - 1)) ?
                       '0 : grant_id + IW'(1);

    always_ff @(posedge system_clock) begin
        if (cpu_rst) state <= IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (any_req) nxt = SEND;
            SEND: begin
                if (sel_valid)      nxt = START;
                else if (stall_hit) nxt = IDLE;
            end
            START: nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (!gap_zero)   nxt = GAP;
                    else if (last_r) nxt = IDLE;
                    else             nxt = SEND;
                end
            end
            GAP:   if (gap_last) nxt = last_r ? IDLE : SEND;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        abort     = 1'b0;
        tx_start  = state == START;
        busy      = state != IDLE;
        if (state == SEND) begin
            req_ready[grant_id] = 1'b1;
            abort = !sel_valid && stall_hit;
        end
    end

    // Grant, gap setting and pointer only move at packet boundaries.
    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            grant_id   <= '0;
            gap_r      <= '0;
            last_r     <= 1'b0;
            tx_data    <= '0;
            gap_cnt    <= '0;
            stall_cnt  <= '0;
            rr_ptr     <= '0;
            byte_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick;
                        gap_r     <= gap_sel;
                        stall_cnt <= '0;
                    end
                end
                SEND: begin
                    if (sel_valid) begin
                        tx_data   <= req_data[{grant_id, 3'b000} +: 8];
                        last_r    <= req_last[grant_id];
                        stall_cnt <= '0;
                    end else if (stall_hit) begin
                        rr_ptr <= nxt_ptr;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                START: byte_count <= byte_count + 16'd1;
                WAIT: begin
                    if (tx_done) begin
                        gap_cnt <= '0;
                        if (gap_zero && last_r) rr_ptr <= nxt_ptr;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_last && last_r) rr_ptr <= nxt_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule
